// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID latch and I-cache handshake.
// A miss parks in WAIT with the address frozen. A branch taken during a miss is kept until the word returns.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] pc_FD,
  output logic [15:0] instr_FD,
  output logic        valid_FD,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_fd_q, pc_fd_d;
  logic [15:0] instr_fd_q, instr_fd_d;
  logic        valid_fd_q, valid_fd_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_pc_q, redir_pc_d;
  logic        bubble, accept;
  logic [15:0] pc_plus2;

  assign pc_plus2  = pc_q + 16'd2;
  assign imem_req  = (state_q != HALT);
  assign imem_addr = pc_q;
  assign pc_FD     = pc_fd_q;
  assign instr_FD  = instr_fd_q;
  assign valid_FD  = valid_fd_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    bubble       = 1'b0;
    accept       = 1'b0;
    if (!stall) begin
      unique case (state_q)
        RUN: begin
          bubble = 1'b1;
          if (branch_taken) begin
            pc_d         = branch_target;
            redir_pend_d = 1'b0;
          end else if (redir_pend_q) begin
            // A redirect left over from a stalled miss return is applied first.
            pc_d         = redir_pc_q;
            redir_pend_d = 1'b0;
          end else if (imem_ready) begin
            bubble = 1'b0;
            accept = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          bubble = 1'b1;
          if (imem_ready) begin
            if (branch_taken || redir_pend_q) begin
              pc_d         = branch_taken ? branch_target : redir_pc_q;
              redir_pend_d = 1'b0;
              state_d      = RUN;
            end else begin
              bubble = 1'b0;
              accept = 1'b1;
            end
          end else if (branch_taken) begin
            redir_pc_d   = branch_target;
            redir_pend_d = 1'b1;
          end
        end
        HALT: begin
          bubble = 1'b1;
          if (branch_taken) begin
            pc_d    = branch_target;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
      if (accept) begin
        if (imem_data[15:12] == HLT_OPCODE) begin
          state_d = HALT;
        end else begin
          pc_d    = pc_plus2;
          state_d = RUN;
        end
      end
    end else if (state_q == WAIT && imem_ready) begin
      // The word returned under stall is dropped; the same pc is fetched again from RUN.
      state_d = RUN;
    end

    pc_fd_d    = pc_fd_q;
    instr_fd_d = instr_fd_q;
    valid_fd_d = valid_fd_q;
    if (bubble) begin
      pc_fd_d    = 16'h0000;
      instr_fd_d = NOP_INSTR;
      valid_fd_d = 1'b0;
    end else if (accept) begin
      pc_fd_d    = pc_plus2;
      instr_fd_d = imem_data;
      valid_fd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pc_fd_q      <= 16'h0000;
      instr_fd_q   <= NOP_INSTR;
      valid_fd_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_fd_q      <= pc_fd_d;
      instr_fd_q   <= instr_fd_d;
      valid_fd_q   <= valid_fd_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Hand-computed expected fetch/IF-ID state is queued per cycle
// and compared after each clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_ready;
  logic [15:0] branch_target, imem_data;
  logic        imem_req, valid_FD, halted;
  logic [15:0] imem_addr, pc_FD, instr_FD;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] pcfd;
    logic [15:0] instr;
    logic        vld;
    logic        hlt;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_ready(imem_ready), .pc_FD(pc_FD),
    .instr_FD(instr_FD), .valid_FD(valid_FD), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, then check it.
  task automatic cyc(input string tag, input logic r, input logic st, input logic bt,
                     input logic [15:0] tgt, input logic rdy, input logic [15:0] d,
                     input logic [15:0] e_addr, input logic [15:0] e_pcfd,
                     input logic [15:0] e_instr, input logic e_vld, input logic e_hlt);
    exp_t e;
    rst = r; stall = st; branch_taken = bt; branch_target = tgt;
    imem_ready = rdy; imem_data = d;
    e.addr = e_addr; e.pcfd = e_pcfd; e.instr = e_instr; e.vld = e_vld; e.hlt = e_hlt; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_addr"},  {16'h0, imem_addr}, {16'h0, e.addr});
      chk({e.tag, "_pcfd"},  {16'h0, pc_FD},     {16'h0, e.pcfd});
      chk({e.tag, "_instr"}, {16'h0, instr_FD},  {16'h0, e.instr});
      chk({e.tag, "_vld"},   {31'h0, valid_FD},  {31'h0, e.vld});
      chk({e.tag, "_hlt"},   {31'h0, halted},    {31'h0, e.hlt});
      chk({e.tag, "_req"},   {31'h0, imem_req},  {31'h0, ~e.hlt});
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    imem_ready = 1'b0; imem_data = 16'h0;
    @(posedge clk); #1;
    // reset state
    cyc("rst",   1, 0, 0, 16'h0000, 1, 16'h1123, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    // T1 straight-line fetch
    cyc("t1a",   0, 0, 0, 16'h0000, 1, 16'h1123, 16'h0002, 16'h0002, 16'h1123, 1, 0);
    cyc("t1b",   0, 0, 0, 16'h0000, 1, 16'h2456, 16'h0004, 16'h0004, 16'h2456, 1, 0);
    // T2 stall freezes everything, branch ignored
    cyc("t2s1",  0, 1, 1, 16'h0080, 1, 16'h3333, 16'h0004, 16'h0004, 16'h2456, 1, 0);
    cyc("t2s2",  0, 1, 1, 16'h0080, 1, 16'h3333, 16'h0004, 16'h0004, 16'h2456, 1, 0);
    cyc("t2res", 0, 0, 0, 16'h0000, 1, 16'h3789, 16'h0006, 16'h0006, 16'h3789, 1, 0);
    // miss then plain hit from WAIT, and stall while a miss returns
    cyc("wmiss", 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 0);
    cyc("wstl",  0, 1, 0, 16'h0000, 1, 16'h7777, 16'h0006, 16'h0000, 16'h0000, 0, 0);
    cyc("whit",  0, 0, 0, 16'h0000, 1, 16'h6789, 16'h0008, 16'h0008, 16'h6789, 1, 0);
    // T3 branch in RUN
    cyc("t3br",  0, 0, 1, 16'h0040, 1, 16'h5A5A, 16'h0040, 16'h0000, 16'h0000, 0, 0);
    cyc("t3nx",  0, 0, 0, 16'h0000, 1, 16'h1AAA, 16'h0042, 16'h0042, 16'h1AAA, 1, 0);
    // T4 branch arriving during a miss at pc=8
    cyc("t4to8", 0, 0, 1, 16'h0008, 1, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    cyc("t4m1",  0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    cyc("t4m2",  0, 0, 1, 16'h0100, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    cyc("t4m3",  0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 0, 0);
    cyc("t4rdy", 0, 0, 0, 16'h0000, 1, 16'h5555, 16'h0100, 16'h0000, 16'h0000, 0, 0);
    cyc("t4nx",  0, 0, 0, 16'h0000, 1, 16'h1234, 16'h0102, 16'h0102, 16'h1234, 1, 0);
    // T5 HLT at pc=6, then redirect out of HALT
    cyc("t5to6", 0, 0, 1, 16'h0006, 1, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 0);
    cyc("t5hlt", 0, 0, 0, 16'h0000, 1, 16'hF000, 16'h0006, 16'h0008, 16'hF000, 1, 1);
    cyc("t5park",0, 0, 0, 16'h0000, 1, 16'h1111, 16'h0006, 16'h0000, 16'h0000, 0, 1);
    cyc("t5br",  0, 0, 1, 16'h0020, 1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 0, 0);
    cyc("t5nx",  0, 0, 0, 16'h0000, 1, 16'h2222, 16'h0022, 16'h0022, 16'h2222, 1, 0);
    // T6 PC wrap, then reset during WAIT
    cyc("t6top", 0, 0, 1, 16'hFFFE, 1, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
    cyc("t6wrap",0, 0, 0, 16'h0000, 1, 16'h4444, 16'h0000, 16'h0000, 16'h4444, 1, 0);
    cyc("t6f",   0, 0, 0, 16'h0000, 1, 16'h1010, 16'h0002, 16'h0002, 16'h1010, 1, 0);
    cyc("t6miss",0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 0);
    cyc("t6rst", 1, 0, 1, 16'h0300, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc("t6run", 0, 0, 0, 16'h0000, 1, 16'h1357, 16'h0002, 16'h0002, 16'h1357, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
